// File: rtl/shared_tlb_miss_sched_pkg.sv
// Shared types for the ITLB/DTLB miss scheduler in front of the shared L2 TLB.
// Widths follow Sv32: 20-bit VPN, 9-bit ASID, 32-bit PTE.
package shared_tlb_miss_sched_pkg;

    localparam int VPN_W  = 20;
    localparam int ASID_W = 9;
    localparam int PTE_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_PTW_REQ,
        ST_PTW_WAIT,
        ST_ACK
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    typedef struct packed {
        side_e              side;
        logic [VPN_W-1:0]   vpn;
        logic [ASID_W-1:0]  asid;
    } req_t;

endpackage

// File: rtl/shared_tlb_miss_sched_rr_arb_2.sv
// Two-way round-robin pick (0 = I side, 1 = D side); a lone requester always wins.
// Purely combinational, zero latency.
module shared_tlb_miss_sched_rr_arb_2 (
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic ptr_i,
    output logic gnt_vld_o,
    output logic gnt_side_o
);

    assign gnt_vld_o  = i_req_i | d_req_i;
    assign gnt_side_o = (i_req_i && d_req_i) ? ptr_i : d_req_i;

endmodule

// File: rtl/shared_tlb_miss_sched.sv
// Serialises ITLB/DTLB misses onto the shared TLB, falls back to the PTW, acks the requester.
// One translation in flight; hit path grant-to-ack is 3 cycles; pending misses wait, held by requesters.
module shared_tlb_miss_sched
    import shared_tlb_miss_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              itlb_miss_i,
    input  logic [VPN_W-1:0]  itlb_vpn_i,
    input  logic              dtlb_miss_i,
    input  logic [VPN_W-1:0]  dtlb_vpn_i,
    input  logic [ASID_W-1:0] asid_i,
    output logic              stlb_req_o,
    output logic [VPN_W-1:0]  stlb_vpn_o,
    output logic [ASID_W-1:0] stlb_asid_o,
    input  logic              stlb_hit_i,
    input  logic [PTE_W-1:0]  stlb_pte_i,
    output logic              ptw_req_o,
    input  logic              ptw_ready_i,
    output logic [VPN_W-1:0]  ptw_vpn_o,
    input  logic              ptw_done_i,
    input  logic [PTE_W-1:0]  ptw_pte_i,
    input  logic              ptw_err_i,
    output logic              itlb_ack_o,
    output logic              dtlb_ack_o,
    output logic [PTE_W-1:0]  fill_pte_o,
    output logic              fill_err_o
);

    state_e             state_q, state_d;
    req_t               req_q, req_d;
    logic [PTE_W-1:0]   pte_q, pte_d;
    logic               err_q, err_d;
    side_e              rr_q, rr_d;
    logic               flush_pend_q, flush_pend_d;

    logic               gnt_vld;
    logic               gnt_side_raw;
    side_e              gnt_side;

    shared_tlb_miss_sched_rr_arb_2 u_rr_arb_2 (
        .i_req_i    (itlb_miss_i),
        .d_req_i    (dtlb_miss_i),
        .ptr_i      (rr_q == SIDE_D),
        .gnt_vld_o  (gnt_vld),
        .gnt_side_o (gnt_side_raw)
    );

    assign gnt_side = side_e'(gnt_side_raw);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        pte_d        = pte_q;
        err_d        = err_q;
        rr_d         = rr_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            ST_IDLE: begin
                // No grant while flushing: the requester may be withdrawing its miss.
                if (gnt_vld && !flush_i) begin
                    req_d.side = gnt_side;
                    req_d.vpn  = (gnt_side == SIDE_I) ? itlb_vpn_i : dtlb_vpn_i;
                    req_d.asid = asid_i;
                    state_d    = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = flush_i ? ST_IDLE : ST_CHECK;
            ST_CHECK: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (stlb_hit_i) begin
                    pte_d   = stlb_pte_i;
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_PTW_REQ;
                end
            end
            ST_PTW_REQ: begin
                // Once the PTW has accepted, the walk must be drained even if flushed.
                if (ptw_ready_i) begin
                    state_d      = ST_PTW_WAIT;
                    flush_pend_d = flush_i;
                end else if (flush_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PTW_WAIT: begin
                if (flush_i) flush_pend_d = 1'b1;
                if (ptw_done_i) begin
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        pte_d   = ptw_pte_i;
                        err_d   = ptw_err_i;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (!flush_i) rr_d = (rr_q == SIDE_I) ? SIDE_D : SIDE_I;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            pte_q        <= '0;
            err_q        <= 1'b0;
            rr_q         <= SIDE_I;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pte_q        <= pte_d;
            err_q        <= err_d;
            rr_q         <= rr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign stlb_req_o  = (state_q == ST_LOOKUP) && !flush_i;
    assign stlb_vpn_o  = req_q.vpn;
    assign stlb_asid_o = req_q.asid;
    assign ptw_req_o   = (state_q == ST_PTW_REQ);
    assign ptw_vpn_o   = req_q.vpn;
    assign itlb_ack_o  = (state_q == ST_ACK) && !flush_i && (req_q.side == SIDE_I);
    assign dtlb_ack_o  = (state_q == ST_ACK) && !flush_i && (req_q.side == SIDE_D);
    assign fill_pte_o  = pte_q;
    assign fill_err_o  = err_q;

endmodule

// File: tb/tb_shared_tlb_miss_sched.sv
// Directed bench for shared_tlb_miss_sched: hit path, round robin, PTW path, faults, flush, reset.
module tb_shared_tlb_miss_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        itlb_miss_i;
    logic [19:0] itlb_vpn_i;
    logic        dtlb_miss_i;
    logic [19:0] dtlb_vpn_i;
    logic [8:0]  asid_i;
    logic        stlb_req_o;
    logic [19:0] stlb_vpn_o;
    logic [8:0]  stlb_asid_o;
    logic        stlb_hit_i;
    logic [31:0] stlb_pte_i;
    logic        ptw_req_o;
    logic        ptw_ready_i;
    logic [19:0] ptw_vpn_o;
    logic        ptw_done_i;
    logic [31:0] ptw_pte_i;
    logic        ptw_err_i;
    logic        itlb_ack_o;
    logic        dtlb_ack_o;
    logic [31:0] fill_pte_o;
    logic        fill_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    shared_tlb_miss_sched dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .itlb_miss_i (itlb_miss_i),
        .itlb_vpn_i  (itlb_vpn_i),
        .dtlb_miss_i (dtlb_miss_i),
        .dtlb_vpn_i  (dtlb_vpn_i),
        .asid_i      (asid_i),
        .stlb_req_o  (stlb_req_o),
        .stlb_vpn_o  (stlb_vpn_o),
        .stlb_asid_o (stlb_asid_o),
        .stlb_hit_i  (stlb_hit_i),
        .stlb_pte_i  (stlb_pte_i),
        .ptw_req_o   (ptw_req_o),
        .ptw_ready_i (ptw_ready_i),
        .ptw_vpn_o   (ptw_vpn_o),
        .ptw_done_i  (ptw_done_i),
        .ptw_pte_i   (ptw_pte_i),
        .ptw_err_i   (ptw_err_i),
        .itlb_ack_o  (itlb_ack_o),
        .dtlb_ack_o  (dtlb_ack_o),
        .fill_pte_o  (fill_pte_o),
        .fill_err_o  (fill_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Advances until the lookup strobe is seen (bounded).
    task automatic wait_lookup(input string tag);
        int n = 0;
        while (!stlb_req_o && n < 6) begin
            tick();
            n++;
        end
        chk({tag, "_lookup"}, 64'(stlb_req_o), 64'h1);
    endtask

    // Completes a shared-TLB hit; returns positioned in the ACK cycle.
    task automatic serve_hit(input string tag, input logic [31:0] pte);
        wait_lookup(tag);
        tick();
        stlb_hit_i = 1'b1;
        stlb_pte_i = pte;
        tick();
        stlb_hit_i = 1'b0;
        stlb_pte_i = '0;
    endtask

    // Drives a shared-TLB miss; returns positioned in the first PTW_REQ cycle.
    task automatic to_ptw_req(input string tag);
        wait_lookup(tag);
        tick();
        tick();
        chk({tag, "_ptw_req"}, 64'(ptw_req_o), 64'h1);
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        itlb_miss_i = 1'b0; itlb_vpn_i = '0; dtlb_miss_i = 1'b0; dtlb_vpn_i = '0;
        asid_i = '0; stlb_hit_i = 1'b0; stlb_pte_i = '0;
        ptw_ready_i = 1'b0; ptw_done_i = 1'b0; ptw_pte_i = '0; ptw_err_i = 1'b0;
        #1;
        chk("rst_outputs", 64'({stlb_req_o, ptw_req_o, itlb_ack_o, dtlb_ack_o, fill_err_o}), 64'h0);
        chk("rst_fill_pte", 64'(fill_pte_o), 64'h0);
        do_reset();

        // 1: ITLB hit, 3 cycles grant to ack
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h12345; asid_i = 9'h1A;
        tick();
        chk("t1_lookup_strobe", 64'(stlb_req_o), 64'h1);
        chk("t1_lookup_vpn", 64'(stlb_vpn_o), 64'h12345);
        chk("t1_lookup_asid", 64'(stlb_asid_o), 64'h1A);
        tick();
        chk("t1_strobe_1cyc", 64'(stlb_req_o), 64'h0);
        stlb_hit_i = 1'b1; stlb_pte_i = 32'hABCD_0001;
        tick();
        stlb_hit_i = 1'b0; stlb_pte_i = '0;
        chk("t1_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        chk("t1_fill_pte", 64'(fill_pte_o), 64'hABCD_0001);
        chk("t1_fill_err", 64'(fill_err_o), 64'h0);
        itlb_miss_i = 1'b0;
        tick();
        chk("t1_ack_pulse", 64'({itlb_ack_o, dtlb_ack_o}), 64'h0);

        // 2: tie with rr_ptr=0 -> I first, then tie grants D, then I
        do_reset();
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h11111;
        dtlb_miss_i = 1'b1; dtlb_vpn_i = 20'h22222;
        tick();
        chk("t2_first_vpn", 64'(stlb_vpn_o), 64'h11111);
        serve_hit("t2a", 32'h100);
        chk("t2_first_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        itlb_vpn_i = 20'h33333;
        tick();
        chk("t2_idle_gap", 64'({itlb_ack_o, dtlb_ack_o, stlb_req_o}), 64'h0);
        tick();
        chk("t2_tie_d_vpn", 64'(stlb_vpn_o), 64'h22222);
        serve_hit("t2b", 32'h200);
        chk("t2_second_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h1);
        chk("t2_second_pte", 64'(fill_pte_o), 64'h200);
        dtlb_miss_i = 1'b0;
        tick();
        tick();
        chk("t2_third_vpn", 64'(stlb_vpn_o), 64'h33333);
        serve_hit("t2c", 32'h300);
        chk("t2_third_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        itlb_miss_i = 1'b0;
        tick();

        // 3: DTLB miss to PTW, ready after 2 cycles
        dtlb_miss_i = 1'b1; dtlb_vpn_i = 20'h00040;
        to_ptw_req("t3");
        chk("t3_ptw_vpn0", 64'(ptw_vpn_o), 64'h00040);
        tick();
        chk("t3_ptw_req_held", 64'(ptw_req_o), 64'h1);
        chk("t3_ptw_vpn1", 64'(ptw_vpn_o), 64'h00040);
        ptw_ready_i = 1'b1;
        tick();
        ptw_ready_i = 1'b0;
        chk("t3_ptw_req_drop", 64'(ptw_req_o), 64'h0);
        tick();
        ptw_done_i = 1'b1; ptw_pte_i = 32'h1F;
        tick();
        ptw_done_i = 1'b0; ptw_pte_i = '0;
        chk("t3_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h1);
        chk("t3_fill_pte", 64'(fill_pte_o), 64'h1F);
        chk("t3_fill_err", 64'(fill_err_o), 64'h0);
        dtlb_miss_i = 1'b0;
        tick();

        // 4: walk fault
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h0ABCD;
        to_ptw_req("t4");
        ptw_ready_i = 1'b1;
        tick();
        ptw_ready_i = 1'b0;
        ptw_done_i = 1'b1; ptw_pte_i = 32'hDEAD; ptw_err_i = 1'b1;
        tick();
        ptw_done_i = 1'b0; ptw_pte_i = '0; ptw_err_i = 1'b0;
        chk("t4_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        chk("t4_fill_err", 64'(fill_err_o), 64'h1);
        chk("t4_fill_pte", 64'(fill_pte_o), 64'hDEAD);
        itlb_miss_i = 1'b0;
        tick();

        // 5: flush during PTW_WAIT, done 5 cycles later -> no ack
        dtlb_miss_i = 1'b1; dtlb_vpn_i = 20'h55555;
        to_ptw_req("t5");
        ptw_ready_i = 1'b1;
        tick();
        ptw_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; dtlb_miss_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_no_ack_wait", 64'({itlb_ack_o, dtlb_ack_o}), 64'h0);
            tick();
        end
        ptw_done_i = 1'b1; ptw_pte_i = 32'h77;
        tick();
        ptw_done_i = 1'b0; ptw_pte_i = '0;
        chk("t5_no_ack_done", 64'({itlb_ack_o, dtlb_ack_o, ptw_req_o}), 64'h0);
        tick();
        chk("t5_no_ack_after", 64'({itlb_ack_o, dtlb_ack_o, stlb_req_o}), 64'h0);
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h66666;
        serve_hit("t5_next", 32'h88);
        chk("t5_next_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        chk("t5_next_pte", 64'(fill_pte_o), 64'h88);
        itlb_miss_i = 1'b0;
        tick();

        // flush in PTW_REQ before ready: request drops, back to IDLE
        dtlb_miss_i = 1'b1; dtlb_vpn_i = 20'h0BEEF;
        to_ptw_req("tf");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0; dtlb_miss_i = 1'b0;
        chk("tf_ptw_req_drop", 64'(ptw_req_o), 64'h0);
        tick();
        chk("tf_idle", 64'({itlb_ack_o, dtlb_ack_o, stlb_req_o, ptw_req_o}), 64'h0);

        // 6: reset in PTW_REQ
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h0F00D;
        to_ptw_req("t6");
        rst_i = 1'b1;
        #1;
        chk("t6_rst_ctrl", 64'({stlb_req_o, ptw_req_o, itlb_ack_o, dtlb_ack_o, fill_err_o}), 64'h0);
        chk("t6_rst_data", 64'({ptw_vpn_o, fill_pte_o}), 64'h0);
        itlb_miss_i = 1'b0;
        tick();
        rst_i = 1'b0;
        itlb_miss_i = 1'b1; itlb_vpn_i = 20'h0AAAA;
        dtlb_miss_i = 1'b1; dtlb_vpn_i = 20'h0BBBB;
        tick();
        chk("t6_rr_reset_vpn", 64'(stlb_vpn_o), 64'h0AAAA);
        serve_hit("t6_after", 32'h99);
        chk("t6_after_acks", 64'({itlb_ack_o, dtlb_ack_o}), 64'h2);
        itlb_miss_i = 1'b0; dtlb_miss_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
